// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared definitions for the back-end control pipeline carrier.
//   CTRL_W      default control bundle width
//   *_BIT/_LSB  field offsets inside the standard decoded bundle
//   stage_slice helper that extracts one stage's bundle from a flattened bus
package ctrl_pipe_pkg;

  localparam int CTRL_W     = 16;
  localparam int MAX_STAGES = 8;

  localparam int MEMTOREG_BIT   = 0;
  localparam int MEMWRITE_BIT   = 1;
  localparam int ALUSRC_BIT     = 2;
  localparam int REGDST_BIT     = 3;
  localparam int REGWRITE_BIT   = 4;
  localparam int ALUCONTROL_LSB = 5;   // ALUCONTROL occupies [12:5]
  localparam int ALUCONTROL_W   = 8;
  localparam int HLWRITE_BIT    = 13;
  localparam int BJAL_BIT       = 14;

  // The bus is sized for the largest supported pipe; narrower buses are
  // zero-extended by the caller.
  function automatic logic [CTRL_W-1:0] stage_slice(
    input logic [MAX_STAGES*CTRL_W-1:0] bus,
    input int unsigned                  k
  );
    return bus[k*CTRL_W +: CTRL_W];
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one pipeline register slice for a control bundle.
//   clk, rst       clock, synchronous active-high reset
//   d, d_valid     bundle offered by the upstream stage or the input
//   hold           keep the current contents
//   flush          clear the slice (wins over hold and load)
//   q, q_valid     registered bundle and its valid flag
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = CTRL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             hold,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] ctrl_d, ctrl_q;
  logic             valid_d, valid_q;

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (flush) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (!hold) begin
      ctrl_d  = d;
      valid_d = d_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign q       = ctrl_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs: carries decoded control bundles through the back-end stages
// (stage 0 = E) with per-stage valid, bubble collapse, stall back-propagation
// and a registered occupancy count.
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ctrl  D-stage bundle; in_ready says stage 0 takes it this cycle
//   stall_i, flush_i  per-stage hold and kill requests (bit 0 = E)
//   out_ctrl          stage k bundle at [k*WIDTH +: WIDTH]; zero when invalid
//   out_valid         per-stage live flag
//   occupancy         registered popcount of out_valid
//   perf_bubble_cnt   edges where the last stage ends up empty; only counts
//                     when CTRL_PIPE_PERF_EN is defined, otherwise tied to 0
module ctrl_pipe_regs
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH  = CTRL_W,
  parameter int STAGES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_ctrl,
  output logic                       in_ready,
  input  logic [STAGES-1:0]          stall_i,
  input  logic [STAGES-1:0]          flush_i,
  output logic [STAGES*WIDTH-1:0]    out_ctrl,
  output logic [STAGES-1:0]          out_valid,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [31:0]                perf_bubble_cnt
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [WIDTH-1:0]  stage_ctrl [STAGES];
  logic [WIDTH-1:0]  src_ctrl   [STAGES];
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] nxt_valid;
  logic [OCC_W-1:0]  occupancy_d, occupancy_q;

  // An empty stage is never held by downstream pressure, so bubbles collapse.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall_i[STAGES-1];
    for (int k = STAGES-2; k >= 0; k--) begin
      hold[k] = stall_i[k] | (hold[k+1] & valid[k]);
    end
  end

  assign in_ready = ~hold[0];

  // A stuck upstream stage hands a bubble downstream instead of duplicating.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      src_ctrl[k]  = '0;
      src_valid[k] = 1'b0;
    end
    src_ctrl[0]  = in_valid ? in_ctrl : '0;
    src_valid[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      if (!hold[k-1]) begin
        src_ctrl[k]  = stage_ctrl[k-1];
        src_valid[k] = valid[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ctrl_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .d       (src_ctrl[k]),
      .d_valid (src_valid[k]),
      .hold    (hold[k]),
      .flush   (flush_i[k]),
      .q       (stage_ctrl[k]),
      .q_valid (valid[k])
    );
    assign out_ctrl[k*WIDTH +: WIDTH] = stage_ctrl[k];

    if (k < STAGES-1) begin : g_no_loss
      a_no_loss: assert property (@(posedge clk) disable iff (rst)
        !(valid[k] && hold[k+1] && !hold[k] && !flush_i[k+1]));
    end
  end

  assign out_valid = valid;

  // Next-state valid mirrors the stage priority so occupancy lands on the
  // same edge as the valid flags.
  always_comb begin
    occupancy_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      nxt_valid[k] = flush_i[k] ? 1'b0 : (hold[k] ? valid[k] : src_valid[k]);
      occupancy_d  = occupancy_d + OCC_W'(nxt_valid[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occupancy_q <= '0;
    else     occupancy_q <= occupancy_d;
  end

  assign occupancy = occupancy_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] perf_bubble_cnt_d, perf_bubble_cnt_q;

  always_comb begin
    perf_bubble_cnt_d = perf_bubble_cnt_q;
    if (!nxt_valid[STAGES-1] && (perf_bubble_cnt_q != 32'hFFFF_FFFF))
      perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_bubble_cnt_q <= '0;
    else     perf_bubble_cnt_q <= perf_bubble_cnt_d;
  end

  assign perf_bubble_cnt = perf_bubble_cnt_q;
`else
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
module tb_ctrl_pipe_regs;
  import ctrl_pipe_pkg::*;

  localparam int W = 16;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_ctrl;
  logic           in_ready;
  logic [S-1:0]   stall_i;
  logic [S-1:0]   flush_i;
  logic [S*W-1:0] out_ctrl;
  logic [S-1:0]   out_valid;
  logic [1:0]     occupancy;
  logic [31:0]    perf_bubble_cnt;

  int         checks   = 0;
  int         failures = 0;
  int         edge_no  = 0;
  logic       retired  = 1'b0;
  logic [W-1:0] sb [$];

  ctrl_pipe_regs #(.WIDTH(W), .STAGES(S)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ctrl         (in_ctrl),
    .in_ready        (in_ready),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .out_ctrl        (out_ctrl),
    .out_valid       (out_valid),
    .occupancy       (occupancy),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] slice_of(input int unsigned k);
    return stage_slice((MAX_STAGES*CTRL_W)'(out_ctrl), k);
  endfunction

  // One clock: record accepted bundles into the scoreboard, advance, and flag
  // a retirement when the last stage freshly loaded a live bundle.
  task automatic cycle();
    logic acc, ps2, pf2;
    #1;
    acc = in_valid && in_ready && !rst;
    ps2 = stall_i[S-1];
    pf2 = flush_i[S-1];
    if (acc) sb.push_back(in_ctrl);
    @(posedge clk);
    #1;
    edge_no++;
    if (rst) begin
      sb.delete();
      retired = 1'b0;
    end else begin
      retired = out_valid[S-1] && !ps2 && !pf2;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; stall_i = '0; flush_i = '0;
    cycle();
    rst = 1'b0;
    edge_no = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 3'b000 || out_ctrl !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ctrl=%h expected 000/0", out_valid, out_ctrl);
    end
    checks++;
    if (occupancy !== 2'd0 || perf_bubble_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_counts: occ=%0d perf=%0d expected 0/0", occupancy, perf_bubble_cnt);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] exp;
    int           nret;
    apply_reset();
    nret = 0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = (i <= 3);
      in_ctrl  = (i <= 3) ? W'(i) : '0;
      cycle();
      if (edge_no == 3) begin
        checks++;
        if (occupancy !== 2'd3) begin
          failures++;
          $display("FAIL stream_occ: got %0d expected 3 at edge 3", occupancy);
        end
      end
      if (retired) begin
        nret++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL stream_sb: got %h with empty scoreboard", slice_of(2));
        end else begin
          exp = sb.pop_front();
          if (slice_of(2) !== exp || edge_no != nret + 2) begin
            failures++;
            $display("FAIL stream_out: got %h at edge %0d expected %h at edge %0d",
                     slice_of(2), edge_no, exp, nret + 2);
          end
        end
      end
    end
    checks++;
    if (nret != 3 || sb.size() != 0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL stream_drain: got retired=%0d left=%0d occ=%0d expected 3/0/0",
               nret, sb.size(), occupancy);
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] exp;
    logic [W-1:0] vals [4];
    vals = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = vals[i];
      cycle();
      if (retired) begin
        checks++;
        exp = sb.pop_front();
        if (slice_of(2) !== exp) begin
          failures++;
          $display("FAIL bp_fill: got %h expected %h", slice_of(2), exp);
        end
      end
    end
    in_ctrl = vals[3];
    stall_i = 3'b100;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (out_ctrl !== {vals[0], vals[1], vals[2]} || out_valid !== 3'b111 || retired) begin
        failures++;
        $display("FAIL bp_hold: got %h valid=%b expected %h valid=111",
                 out_ctrl, out_valid, {vals[0], vals[1], vals[2]});
      end
    end
    stall_i = 3'b000;
    cycle();
    checks++;
    if (out_ctrl !== {vals[1], vals[2], vals[3]} || out_valid !== 3'b111) begin
      failures++;
      $display("FAIL bp_resume: got %h expected %h", out_ctrl, {vals[1], vals[2], vals[3]});
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (retired) begin
        checks++;
        exp = (sb.size() != 0) ? sb.pop_front() : 16'hDEAD;
        if (slice_of(2) !== exp) begin
          failures++;
          $display("FAIL bp_drain: got %h expected %h", slice_of(2), exp);
        end
      end
      cycle();
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 3'b000) begin
      failures++;
      $display("FAIL bp_empty: got left=%0d valid=%b expected 0/000", sb.size(), out_valid);
    end
  endtask

  task automatic test_bubble_collapse();
    apply_reset();
    in_valid = 1'b1; in_ctrl = 16'h1111;   // Y
    cycle();
    in_ctrl = 16'h2222;                    // X
    cycle();
    in_valid = 1'b0;
    cycle();
    if (retired) void'(sb.pop_front());
    stall_i = 3'b100; in_valid = 1'b1; in_ctrl = 16'h00AA;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bubble_ready_before: got %b expected 1", in_ready);
    end
    cycle();
    checks++;
    if (out_ctrl !== {16'h1111, 16'h2222, 16'h00AA} || out_valid !== 3'b111) begin
      failures++;
      $display("FAIL bubble_load: got %h valid=%b expected 1111222200aa valid=111",
               out_ctrl, out_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bubble_ready_after: got %b expected 0", in_ready);
    end
    stall_i = 3'b000; in_valid = 1'b0;
    cycle();
    checks++;
    if (!retired || slice_of(2) !== 16'h2222) begin
      failures++;
      $display("FAIL bubble_release: got %h retired=%b expected 2222", slice_of(2), retired);
    end
    sb.delete();
  endtask

  task automatic test_flush_priority();
    logic [W-1:0] exp;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = W'(16'h0100 + i);
      cycle();
      if (retired) void'(sb.pop_front());
    end
    in_valid = 1'b0; stall_i = 3'b001; flush_i = 3'b001;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_backpressure: in_ready got %b expected 0", in_ready);
    end
    void'(sb.pop_back());   // E's bundle is killed and never retires
    cycle();
    checks++;
    if (out_valid !== 3'b100 || out_ctrl !== {16'h0101, 16'h0000, 16'h0000}) begin
      failures++;
      $display("FAIL flush_state: got %h valid=%b expected 010100000000 valid=100",
               out_ctrl, out_valid);
    end
    checks++;
    if (occupancy !== 2'd1) begin
      failures++;
      $display("FAIL flush_occ: got %0d expected 1", occupancy);
    end
    if (retired) begin
      checks++;
      exp = (sb.size() != 0) ? sb.pop_front() : 16'hDEAD;
      if (slice_of(2) !== exp) begin
        failures++;
        $display("FAIL flush_retire: got %h expected %h", slice_of(2), exp);
      end
    end
    stall_i = '0; flush_i = '0;
    cycle();
    checks++;
    if (occupancy !== 2'd0 || sb.size() != 0) begin
      failures++;
      $display("FAIL flush_drain: got occ=%0d left=%0d expected 0/0", occupancy, sb.size());
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = W'(16'h5500 + i);
      cycle();
    end
    stall_i = 3'b111; in_ctrl = 16'h7777;
    cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 3'b000 || out_ctrl !== '0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL rst_stall: got valid=%b ctrl=%h occ=%0d expected 000/0/0",
               out_valid, out_ctrl, occupancy);
    end
    rst = 1'b0; stall_i = 3'b000; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_stall_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp;
`ifdef CTRL_PIPE_PERF_EN
    exp = 32'd10;
`else
    exp = 32'd0;
`endif
    apply_reset();
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (perf_bubble_cnt !== exp) begin
      failures++;
      $display("FAIL perf_idle: got %0d expected %0d", perf_bubble_cnt, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; stall_i = '0; flush_i = '0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_bubble_collapse();
    test_flush_priority();
    test_reset_mid_stall();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
